noc_inject_arbiter: RTL and testbench
=====================================

// Module: noc_inject_arbiter
// PURPOSE
// - Shares one NoC local injection port between NUM_REQ packet sources (test nodes, DMA, AXI bridges).
// - Arbitrates round-robin at packet granularity with wormhole locking: header..tail of one packet are never interleaved.
// - Registered single-entry output stage feeds the router local input; counts packets and flags protocol errors.
// PARAMETERS
// - NUM_REQ   4                  number of requesters (2..8)
// - DATA_W    `Noc_Data_Width    flit payload width
// - CNT_W     16                 width of the forwarded-packet counter
// PORTS
// - noc_clk          in   1                the one clock
// - noc_rst          in   1                synchronous, active-high reset
// - req_valid        in   NUM_REQ          per-requester flit valid
// - req_ready        out  NUM_REQ          per-requester flit accept (combinational)
// - req_flit         in   NUM_REQ*DATA_W   flits packed; requester i at [i*DATA_W +: DATA_W]
// - req_is_header    in   NUM_REQ          flit is a packet header
// - req_is_tail      in   NUM_REQ          flit is a packet tail (header+tail = single-flit packet)
// - out_valid        out  1                flit to router valid (registered)
// - out_ready        in   1                router accepts
// - out_flit         out  DATA_W           flit to router (registered)
// - out_is_header    out  1                registered
// - out_is_tail      out  1                registered
// - busy             out  1                1 while in LOCKED
// - grant_id         out  $clog2(NUM_REQ)  owner of current/last packet
// - pkt_count        out  CNT_W            tails forwarded; wraps to 0 after all-ones
// - proto_err        out  1                sticky; cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; state=IDLE; rr_ptr=0; out stage empty.
// - Stage free: can_load = !out_valid | out_ready.
// - in_fire = the selected requester's req_valid & req_ready. At most one req_ready is high per cycle.
// - IDLE
//   - Candidates are requesters with req_valid & req_is_header.
//   - Winner = first candidate at or after rr_ptr, searching cyclically.
//   - req_ready[winner] = can_load.
//   - On in_fire with !is_tail: go to LOCKED, owner=winner, grant_id=winner.
//   - On in_fire of a single-flit packet: stay IDLE, rr_ptr=winner+1 (mod NUM_REQ), pkt_count++.
// - LOCKED
//   - req_ready[owner] = can_load; all other req_ready=0.
//   - Owner flit with is_tail fires: go to IDLE, rr_ptr=owner+1 (mod NUM_REQ), pkt_count++.
// - Output stage
//   - On in_fire, load flit/header/tail and set out_valid=1 at the next edge.
//   - Else if out_ready, clear out_valid.
//   - Latency 1 cycle. Back-to-back throughput of 1 flit/cycle when out_ready is held high.
//   - out_* is held stable while out_valid & !out_ready.
// - Protocol errors set proto_err and are never forwarded:
//   - In IDLE, a valid non-header flit is ignored (ready=0).
//   - In LOCKED, an owner flit with is_header=1 is refused (ready=0) and the block stays LOCKED.
//   - Only that owner can then unlock, by sending a tail.
// - Requesters that drop valid mid-packet keep the lock. There is no timeout; other requesters wait.
// - Simultaneous headers are resolved by rr_ptr only. No requester waits more than NUM_REQ-1 packets.
// - Reset mid-packet drops the lock and the out stage. The router side must be reset together with this block.
// STRUCTURE
// - Shared package/`include (Noc_parameters.v): `Noc_Data_Width, flit header/tail field constants.
// - Sub-module rr_arbiter: NUM_REQ request vector + rr_ptr in, one-hot grant + index out, purely combinational.
// - The FSM, owner register and output stage live here.
// TESTING
// - Single requester 0, 3-flit packet H,D,T, out_ready=1:
//   - out_valid high cycles 1..3 with H,D,T.
//   - pkt_count=1, busy low after T, rr_ptr=1.
// - Req 0 and 2 both present headers at the same cycle from reset:
//   - Req 0's whole packet goes out first, then req 2's.
//   - No interleave; grant_id 0 then 2.
// - All 4 requesters stream packets continuously:
//   - Grant order 0,1,2,3,0...
//   - pkt_count=8 after 8 packets.
// - out_ready held 0 for 5 cycles mid-packet:
//   - out_flit is stable.
//   - req_ready[owner]=0 while the stage is full.
//   - Resumes with no loss or duplicate.
// - Protocol errors:
//   - Data flit from req 1 in IDLE -> req_ready[1]=0, proto_err=1.
//   - Header from the owner while LOCKED -> refused, proto_err=1.
// - Assert noc_rst for 1 cycle while LOCKED:
//   - Next cycle out_valid=0, busy=0, pkt_count=0.
//   - A fresh header from req 3 is granted.

Source files
------------

// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC local-injection arbiter slice.
//   NOC_DATA_WIDTH : default flit payload width
//   arb_state_e    : arbiter FSM states (IDLE = free for a new header,
//                    LOCKED = wormhole owned by one requester until its tail)
//   wrap_inc       : modulo increment used to advance the round-robin pointer
package noc_inject_arbiter_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Handshake bundle between the packet sources, the arbiter and the router
// local input port.
//   req_valid/req_ready      per-requester flit handshake
//   req_flit                 packed flits, requester i at [i*DATA_W +: DATA_W]
//   req_is_header/is_tail    per-requester packet framing
//   out_valid/out_ready      registered flit handshake towards the router
//   out_flit/out_is_header/out_is_tail  registered flit and framing
// slave  : arbiter view; master : environment (sources + router) view.
interface noc_inject_arbiter_if
  import noc_inject_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = NOC_DATA_WIDTH
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;

  modport slave (
    input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    output req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

  modport master (
    output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    input  req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );
endinterface

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   rr_ptr    : highest-priority index this cycle
//   grant     : one-hot grant (zero when nothing requests)
//   grant_idx : index of the granted requester
//   grant_any : at least one request present
// The winner is the first requester at or after rr_ptr, searching cyclically.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    logic [IDX_W-1:0] pos;
    pos       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!grant_any && req[pos]) begin
        grant_any  = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Shares one NoC local injection port between NUM_REQ packet sources.
// Round-robin arbitration at packet granularity with wormhole locking, a
// registered single-entry output stage, a forwarded-packet counter and a
// sticky protocol-error flag.
//   noc_clk    clock
//   noc_rst    synchronous active-high reset
//   bus        handshake bundle (slave modport)
//   busy       high while a packet holds the lock
//   grant_id   owner of the current/last packet
//   pkt_count  number of tails forwarded (wraps)
//   proto_err  sticky; set by a non-header flit in IDLE or a header from
//              the owner while LOCKED; cleared only by reset
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = NOC_DATA_WIDTH,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst,
  noc_inject_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic [CNT_W-1:0]     pkt_count,
  output logic                 proto_err
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic [CNT_W-1:0]   pkt_count_q;
  logic               proto_err_q;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_flit_q;
  logic               out_is_header_q;
  logic               out_is_tail_q;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic               can_load;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ok;
  logic               in_fire;
  logic               err_now;
  logic [DATA_W-1:0]  sel_flit;
  logic               sel_hdr;
  logic               sel_tail;

  // Only headers compete for a free port; stray body flits are errors.
  assign cand     = bus.req_valid & bus.req_is_header;
  assign can_load = !out_valid_q || bus.out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (cand),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  always_ff @(posedge noc_clk) begin
    if (noc_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    sel_idx       = arb_idx;
    sel_ok        = 1'b0;
    err_now       = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        sel_idx = arb_idx;
        sel_ok  = arb_any;
        if (can_load) bus.req_ready = arb_grant;
        err_now = |(bus.req_valid & ~bus.req_is_header);
      end
      ST_LOCKED: begin
        // A header from the owner is refused; the lock stays until its tail.
        sel_idx = owner_q;
        sel_ok  = bus.req_valid[owner_q] & ~bus.req_is_header[owner_q];
        if (can_load && sel_ok) bus.req_ready[owner_q] = 1'b1;
        err_now = bus.req_valid[owner_q] & bus.req_is_header[owner_q];
      end
      default: ;
    endcase

    in_fire  = sel_ok && can_load;

    sel_flit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel_idx) sel_flit = bus.req_flit[i*DATA_W +: DATA_W];
    end
    sel_hdr  = bus.req_is_header[sel_idx];
    sel_tail = bus.req_is_tail[sel_idx];

    if (in_fire) state_d = sel_tail ? ST_IDLE : ST_LOCKED;
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      grant_id_q      <= '0;
      pkt_count_q     <= '0;
      proto_err_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_flit_q      <= '0;
      out_is_header_q <= 1'b0;
      out_is_tail_q   <= 1'b0;
    end else begin
      if (err_now) proto_err_q <= 1'b1;

      if (in_fire) begin
        out_valid_q     <= 1'b1;
        out_flit_q      <= sel_flit;
        out_is_header_q <= sel_hdr;
        out_is_tail_q   <= sel_tail;
        if (state_q == ST_IDLE) begin
          owner_q    <= sel_idx;
          grant_id_q <= sel_idx;
        end
        if (sel_tail) begin
          pkt_count_q <= pkt_count_q + CNT_W'(1);
          rr_ptr_q    <= IDX_W'(wrap_inc(32'(sel_idx), NUM_REQ));
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_flit      = out_flit_q;
  assign bus.out_is_header = out_is_header_q;
  assign bus.out_is_tail   = out_is_tail_q;

  assign busy      = (state_q == ST_LOCKED);
  assign grant_id  = grant_id_q;
  assign pkt_count = pkt_count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter. Sources are modelled as per-requester
// flit queues; a packet-level reference (owner/pointer/stage as plain ints)
// predicts req_ready and every output each cycle, and literal expectations
// pin the router-side flit order and grant sequence for each scenario.
module tb_noc_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int QD = 64;

  logic        noc_clk = 1'b0;
  logic        noc_rst = 1'b1;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] pkt_count;
  logic        proto_err;

  noc_inject_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  noc_inject_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .noc_clk   (noc_clk),
    .noc_rst   (noc_rst),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .pkt_count (pkt_count),
    .proto_err (proto_err)
  );

  always #5 noc_clk = ~noc_clk;

  // Source queues
  logic [DW-1:0] s_flit [NR][QD];
  bit            s_h    [NR][QD];
  bit            s_t    [NR][QD];
  int            src_hd [NR];
  int            src_tl [NR];

  bit rtr_ready = 1'b1;
  bit rst_req   = 1'b1;

  // Reference model state
  bit            m_locked = 0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  bit            m_ov     = 0;
  logic [DW-1:0] m_of     = '0;
  bit            m_oh     = 0;
  bit            m_ot     = 0;
  int            m_cnt    = 0;
  bit            m_err    = 0;
  int            m_gid    = 0;

  logic [DW-1:0] rlog [$];
  int            glog [$];
  logic [DW-1:0] exp_f [$];
  int            exp_g [$];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic clear_q();
    for (int i = 0; i < NR; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] fl, input bit h, input bit t);
    s_flit[r][src_tl[r]] = fl;
    s_h[r][src_tl[r]]    = h;
    s_t[r][src_tl[r]]    = t;
    src_tl[r]++;
  endtask

  // Flit value = {requester, tag, flit index}
  task automatic push_pkt(input int r, input int len, input logic [7:0] tag);
    for (int k = 0; k < len; k++)
      push(r, {8'(r), tag, 16'(k)}, k == 0, k == len - 1);
  endtask

  task automatic cycle();
    logic [NR-1:0]    v, h, t, rdy;
    logic [NR*DW-1:0] f;
    int               sel;
    int               j;
    bit               cl;
    v = '0; h = '0; t = '0; f = '0; rdy = '0;
    @(negedge noc_clk);
    for (int i = 0; i < NR; i++) begin
      if (src_hd[i] != src_tl[i]) begin
        v[i]         = 1'b1;
        h[i]         = s_h[i][src_hd[i]];
        t[i]         = s_t[i][src_hd[i]];
        f[i*DW +: DW] = s_flit[i][src_hd[i]];
      end
    end
    bus.req_valid     = v;
    bus.req_is_header = h;
    bus.req_is_tail   = t;
    bus.req_flit      = f;
    bus.out_ready     = rtr_ready;
    noc_rst           = rst_req;
    #1;
    // Expected acceptance: free port -> first header at/after pointer;
    // locked -> only the owner's non-header flit.
    cl  = !m_ov || rtr_ready;
    sel = -1;
    if (!m_locked) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (sel < 0 && v[j] && h[j]) sel = j;
      end
    end else if (v[m_owner] && !h[m_owner]) begin
      sel = m_owner;
    end
    if (sel >= 0 && cl) rdy[sel] = 1'b1;

    check("req_ready",     bus.req_ready,     rdy);
    check("out_valid",     bus.out_valid,     m_ov);
    check("out_flit",      bus.out_flit,      m_of);
    check("out_is_header", bus.out_is_header, m_oh);
    check("out_is_tail",   bus.out_is_tail,   m_ot);
    check("busy",          busy,              m_locked);
    check("grant_id",      grant_id,          m_gid);
    check("pkt_count",     pkt_count,         m_cnt);
    check("proto_err",     proto_err,         m_err);

    if (!rst_req && bus.out_valid && rtr_ready) begin
      rlog.push_back(bus.out_flit);
      if (bus.out_is_header) glog.push_back(int'(grant_id));
    end

    @(posedge noc_clk);
    if (rst_req) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_of = '0;
      m_oh = 0; m_ot = 0; m_cnt = 0; m_err = 0; m_gid = 0;
    end else begin
      if (!m_locked) begin
        for (int i = 0; i < NR; i++) if (v[i] && !h[i]) m_err = 1;
      end else if (v[m_owner] && h[m_owner]) begin
        m_err = 1;
      end
      if (sel >= 0 && cl) begin
        m_ov = 1;
        m_of = f[sel*DW +: DW];
        m_oh = h[sel];
        m_ot = t[sel];
        if (!m_locked) m_gid = sel;
        if (t[sel]) begin
          m_cnt    = (m_cnt + 1) % 65536;
          m_ptr    = (sel + 1) % NR;
          m_locked = 0;
        end else begin
          m_locked = 1;
          m_owner  = sel;
        end
        src_hd[sel]++;
      end else if (rtr_ready) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    clear_q();
    rst_req = 1;
    cycle();
    rst_req = 0;
    rlog.delete();
    glog.delete();
  endtask

  task automatic cmp_log(input string nm);
    check({nm, "_flit_count"}, rlog.size(), exp_f.size());
    for (int i = 0; i < exp_f.size(); i++)
      if (i < rlog.size()) check({nm, "_flit"}, rlog[i], exp_f[i]);
    exp_f.delete();
  endtask

  task automatic cmp_glog(input string nm);
    check({nm, "_grant_count"}, glog.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++)
      if (i < glog.size()) check({nm, "_grant"}, glog[i], exp_g[i]);
    exp_g.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rtr_ready = 1;
    do_reset();
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      busy,          0);
    check("rst_pkt_count", pkt_count,     0);
    check("rst_proto_err", proto_err,     0);
    check("rst_grant_id",  grant_id,      0);

    // Single 3-flit packet from requester 0
    push_pkt(0, 3, 8'h01);
    run(5);
    #2;
    exp_f = '{32'h0001_0000, 32'h0001_0001, 32'h0001_0002};
    cmp_log("t1");
    check("t1_pkt_count", pkt_count, 1);
    check("t1_busy",      busy,      0);
    // Pointer now at 1: req1 beats req0 on simultaneous headers
    rlog.delete(); glog.delete();
    push_pkt(0, 1, 8'h02);
    push_pkt(1, 1, 8'h03);
    run(4);
    #2;
    exp_f = '{32'h0103_0000, 32'h0002_0000};
    cmp_log("t1_rr");

    // Simultaneous headers from req0 and req2 after reset
    do_reset();
    push_pkt(0, 3, 8'h10);
    push_pkt(2, 3, 8'h12);
    run(9);
    #2;
    exp_f = '{32'h0010_0000, 32'h0010_0001, 32'h0010_0002,
              32'h0212_0000, 32'h0212_0001, 32'h0212_0002};
    cmp_log("t2");
    exp_g = '{0, 2};
    cmp_glog("t2");

    // All four requesters streaming 2-flit packets
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NR; r++) push_pkt(r, 2, 8'(8'h20 + rep));
    run(20);
    #2;
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    cmp_glog("t3");
    check("t3_pkt_count", pkt_count, 8);

    // Router stall mid-packet
    do_reset();
    push_pkt(1, 5, 8'h40);
    run(3);
    rtr_ready = 0;
    run(5);
    #2;
    check("t4_stall_flit",  bus.out_flit,  32'h0140_0002);
    check("t4_stall_valid", bus.out_valid, 1);
    check("t4_stall_ready", bus.req_ready, 4'b0000);
    check("t4_stall_busy",  busy,          1);
    rtr_ready = 1;
    run(5);
    #2;
    exp_f = '{32'h0140_0000, 32'h0140_0001, 32'h0140_0002, 32'h0140_0003, 32'h0140_0004};
    cmp_log("t4");
    check("t4_pkt_count", pkt_count, 1);

    // Data flit from req1 while IDLE
    do_reset();
    push(1, 32'h0150_0000, 0, 0);
    run(3);
    #2;
    check("t5_idle_ready", bus.req_ready, 4'b0000);
    check("t5_idle_err",   proto_err,     1);
    check("t5_idle_fwd",   rlog.size(),   0);

    // Header from the owner while LOCKED; another requester waits
    do_reset();
    push(0, 32'h0051_0000, 1, 0);
    push(0, 32'h0051_00ee, 1, 0);
    push_pkt(2, 1, 8'h52);
    run(3);
    #2;
    check("t5_lock_err",   proto_err,     1);
    check("t5_lock_busy",  busy,          1);
    check("t5_lock_ready", bus.req_ready, 4'b0000);
    src_hd[0]++;
    push(0, 32'h0051_0001, 0, 1);
    run(6);
    #2;
    exp_f = '{32'h0051_0000, 32'h0051_0001, 32'h0252_0000};
    cmp_log("t5");
    exp_g = '{0, 2};
    cmp_glog("t5");
    check("t5_err_sticky", proto_err, 1);
    check("t5_busy_end",   busy,      0);

    // Reset while LOCKED
    do_reset();
    push_pkt(0, 1, 8'h60);
    push_pkt(1, 4, 8'h61);
    run(3);
    #2;
    check("t6_pre_busy",  busy,      1);
    check("t6_pre_count", pkt_count, 1);
    do_reset();
    #2;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy",      busy,          0);
    check("t6_pkt_count", pkt_count,     0);
    push_pkt(3, 2, 8'h63);
    run(4);
    #2;
    exp_f = '{32'h0363_0000, 32'h0363_0001};
    cmp_log("t6");
    exp_g = '{3};
    cmp_glog("t6");
    check("t6_grant_id", grant_id, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
